// File: rtl/d_flip_flop_1bit.sv
// d_flip_flop_1bit: rising-edge 1-bit register with sync reset, clock enable and complemented output
// ports: clk clock | rst sync active-high reset | en clock enable | D data in | Q registered data | Q_n ~Q
module d_flip_flop_1bit #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic D,
  output logic Q,
  output logic Q_n
);
  always_ff @(posedge clk) Q <= rst ? RESET_VALUE : (en ? D : Q);
  assign Q_n = ~Q;
endmodule

// File: tb/tb_d_flip_flop_1bit.sv
// tb_d_flip_flop_1bit: randomized and directed checks of d_flip_flop_1bit against an edge-level model
module tb_d_flip_flop_1bit;
  logic clk = 1'b0;
  logic rst, en, D;
  logic q0, qn0, q1, qn1;
  logic m0, m1;
  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  d_flip_flop_1bit #(.RESET_VALUE(1'b0)) dut0 (.clk(clk), .rst(rst), .en(en), .D(D), .Q(q0), .Q_n(qn0));
  d_flip_flop_1bit #(.RESET_VALUE(1'b1)) dut1 (.clk(clk), .rst(rst), .en(en), .D(D), .Q(q1), .Q_n(qn1));

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q0"}, q0, m0);
    chk({tag, ".qn0"}, qn0, ~m0);
    chk({tag, ".q1"}, q1, m1);
    chk({tag, ".qn1"}, qn1, ~m1);
  endtask

  task automatic step(input logic r, input logic e, input logic d, input string tag);
    rst = r;
    en = e;
    D = d;
    @(posedge clk);
    #1;
    if (r) begin
      m0 = 1'b0;
      m1 = 1'b1;
    end else if (e) begin
      m0 = d;
      m1 = d;
    end
    check_all(tag);
  endtask

  task automatic glitch(input string tag);
    #1 D = ~D; rst = 1'b1; en = ~en;
    #1 check_all(tag);
    #1 D = ~D; rst = 1'b0;
    #1 check_all({tag, ".b"});
  endtask

  initial begin
    rst = 1'b0;
    en = 1'b1;
    D = 1'b0;
    step(1, 1, 1, "reset");
    step(0, 1, 0, "cap0");
    step(0, 1, 1, "cap1");
    step(0, 0, 0, "hold1");
    step(0, 0, 0, "hold2");
    step(0, 0, 0, "hold3");
    step(0, 1, 0, "en_load");
    step(0, 1, 1, "set1");
    step(1, 1, 1, "rst_prio");
    step(0, 1, 1, "rst_release");
    glitch("no_edge1");
    step(0, 0, 1, "hold_after_glitch");
    step(0, 1, 0, "cap_low");
    glitch("no_edge0");
    step(1, 0, 0, "rst_no_en");
    for (int i = 0; i < 200; i++) begin
      logic r, e, d;
      r = ($urandom_range(7) == 0);
      e = $urandom_range(1);
      d = $urandom_range(1);
      step(r, e, d, "rand");
      if ($urandom_range(9) == 0) glitch("rand_no_edge");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
